// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle between a producer/consumer and sync_fifo_flex.
// The master side drives requests; the slave side (the FIFO) drives status and read data.
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PW:0]           count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wdata, rd_en,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wdata, rd_en,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty,
// sticky overflow/underflow, synchronous flush and selectable FWFT read mode.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4,
  parameter bit FWFT       = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_fifo_flex_if.slave   bus
);
  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] AF_C    = (PW+1)'(AF_THRESH);
  localparam logic [PW:0] AE_C    = (PW+1)'(AE_THRESH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full_w, empty_w, wr_acc, rd_acc;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // Flush swallows any request in its cycle, so acceptance is gated here once.
  assign wr_acc = bus.wr_en && !full_w  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty_w && !bus.flush;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q  | (bus.wr_en && full_w);
      underflow_d = underflow_q | (bus.rd_en && empty_w);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[PW-1:0]] <= bus.wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head entry is always visible; a write into an empty FIFO shows up right after its edge.
      assign bus.rdata  = mem_q[rd_ptr_q[PW-1:0]];
      assign bus.rvalid = !empty_w;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
      logic                  rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_acc;
        if (rd_acc) rdata_d = mem_q[rd_ptr_q[PW-1:0]];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign bus.rdata  = rdata_q;
      assign bus.rvalid = rvalid_q;
    end
  endgenerate

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a standard-mode and an FWFT instance at default sizes.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_sync_fifo_flex;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) f ();
  sync_fifo_flex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) g ();

  sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1'b0))
    dut_std (.clk(clk), .rst_n(rst_n), .bus(f));
  sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1'b1))
    dut_fwft (.clk(clk), .rst_n(rst_n), .bus(g));

  logic [7:0] q[$];

  // {full, empty, almost_full, almost_empty, overflow, underflow, rvalid}
  function automatic logic [6:0] flags_f();
    return {f.full, f.empty, f.almost_full, f.almost_empty, f.overflow, f.underflow, f.rvalid};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f.flush = 0; f.wr_en = 0; f.rd_en = 0; f.wdata = '0;
    g.flush = 0; g.wr_en = 0; g.rd_en = 0; g.wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    cycle(); cycle();
    rst_n = 1;
    n_checks++;
    if (f.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", f.count); end
    n_checks++;
    if (flags_f() !== 7'b0101000) begin n_fail++; $display("FAIL reset_flags: got %b want 0101000", flags_f()); end
    n_checks++;
    if (f.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", f.rdata); end
    n_checks++;
    if ({g.empty, g.rvalid, g.count} !== {1'b1, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL reset_fwft: empty=%b rvalid=%b count=%0d want 1 0 0", g.empty, g.rvalid, g.count);
    end
  endtask

  task automatic test_fill_overflow();
    logic [6:0] exp;
    for (int i = 0; i < 16; i++) begin
      f.wr_en = 1; f.wdata = 8'(i);
      cycle();
      exp = {(i == 15), 1'b0, (i + 1 >= 12), (i + 1 <= 4), 3'b000};
      n_checks++;
      if (f.count !== 5'(i + 1) || flags_f() !== exp) begin
        n_fail++; $display("FAIL fill_%0d: count=%0d flags=%b want count=%0d flags=%b", i, f.count, flags_f(), i + 1, exp);
      end
    end
    f.wdata = 8'hEE;
    cycle();
    f.wr_en = 0;
    n_checks++;
    if (f.count !== 5'd16 || flags_f() !== 7'b1010100) begin
      n_fail++; $display("FAIL overflow_write: count=%0d flags=%b want 16 1010100", f.count, flags_f());
    end
    cycle();
    n_checks++;
    if (f.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b want 1", f.overflow); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < 16; i++) begin
      f.rd_en = 1;
      cycle();
      f.rd_en = 0;
      n_checks++;
      if ({f.rvalid, f.rdata, f.count} !== {1'b1, 8'(i), 5'(15 - i)}) begin
        n_fail++; $display("FAIL drain_%0d: rvalid=%b rdata=%h count=%0d want 1 %h %0d", i, f.rvalid, f.rdata, f.count, 8'(i), 15 - i);
      end
      cycle();
      n_checks++;
      if ({f.rvalid, f.rdata} !== {1'b0, 8'(i)}) begin
        n_fail++; $display("FAIL drain_pulse_%0d: rvalid=%b rdata=%h want 0 %h", i, f.rvalid, f.rdata, 8'(i));
      end
    end
    n_checks++;
    if (flags_f() !== 7'b0101100) begin n_fail++; $display("FAIL drained_flags: got %b want 0101100", flags_f()); end
    f.rd_en = 1;
    cycle();
    f.rd_en = 0;
    n_checks++;
    if (flags_f() !== 7'b0101110 || f.count !== 5'd0) begin
      n_fail++; $display("FAIL underflow_read: flags=%b count=%0d want 0101110 0", flags_f(), f.count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 10; i++) begin
      f.wr_en = 1; f.wdata = 8'(8'h40 + i); q.push_back(f.wdata); cycle();
    end
    f.wr_en = 0;
    for (int i = 0; i < 10; i++) begin
      f.rd_en = 1; cycle(); exp = q.pop_front();
      n_checks++;
      if ({f.rvalid, f.rdata} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL wrap_a_%0d: rvalid=%b rdata=%h want 1 %h", i, f.rvalid, f.rdata, exp);
      end
    end
    f.rd_en = 0;
    for (int i = 0; i < 16; i++) begin
      f.wr_en = 1; f.wdata = 8'(8'h80 + i); q.push_back(f.wdata); cycle();
    end
    f.wr_en = 0;
    n_checks++;
    if ({f.full, f.count} !== {1'b1, 5'd16}) begin
      n_fail++; $display("FAIL wrap_full: full=%b count=%0d want 1 16", f.full, f.count);
    end
    for (int i = 0; i < 16; i++) begin
      f.rd_en = 1; cycle(); exp = q.pop_front();
      n_checks++;
      if ({f.rvalid, f.rdata} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL wrap_b_%0d: rvalid=%b rdata=%h want 1 %h", i, f.rvalid, f.rdata, exp);
      end
    end
    f.rd_en = 0;
    n_checks++;
    if ({f.empty, f.count} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL wrap_empty: empty=%b count=%0d want 1 0", f.empty, f.count);
    end
  endtask

  task automatic test_steady_state();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      f.wr_en = 1; f.wdata = 8'(8'h10 + i); q.push_back(f.wdata); cycle();
    end
    for (int i = 0; i < 20; i++) begin
      f.wr_en = 1; f.rd_en = 1; f.wdata = 8'(8'h20 + i); q.push_back(f.wdata);
      cycle();
      exp = q.pop_front();
      n_checks++;
      if ({f.rvalid, f.rdata, f.count, f.full, f.empty, f.almost_full, f.almost_empty} !==
          {1'b1, exp, 5'd5, 4'b0000}) begin
        n_fail++; $display("FAIL steady_%0d: rvalid=%b rdata=%h count=%0d fl=%b%b%b%b want 1 %h 5 0000", i,
          f.rvalid, f.rdata, f.count, f.full, f.empty, f.almost_full, f.almost_empty, exp);
      end
    end
    f.wr_en = 0;
    for (int i = 0; i < 5; i++) begin
      f.rd_en = 1; cycle(); exp = q.pop_front();
      n_checks++;
      if ({f.rvalid, f.rdata} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL steady_drain_%0d: rvalid=%b rdata=%h want 1 %h", i, f.rvalid, f.rdata, exp);
      end
    end
    f.rd_en = 0;
  endtask

  task automatic test_fwft();
    g.wr_en = 1; g.wdata = 8'hA5; cycle(); g.wr_en = 0;
    n_checks++;
    if ({g.rvalid, g.rdata, g.empty} !== {1'b1, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL fwft_write: rvalid=%b rdata=%h empty=%b want 1 a5 0", g.rvalid, g.rdata, g.empty);
    end
    cycle();
    n_checks++;
    if ({g.rvalid, g.rdata} !== {1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL fwft_hold: rvalid=%b rdata=%h want 1 a5", g.rvalid, g.rdata);
    end
    g.rd_en = 1; cycle(); g.rd_en = 0;
    n_checks++;
    if ({g.empty, g.rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL fwft_pop: empty=%b rvalid=%b want 1 0", g.empty, g.rvalid);
    end
    g.wr_en = 1; g.wdata = 8'h3C; cycle();
    g.wdata = 8'h5A; cycle(); g.wr_en = 0;
    g.rd_en = 1; cycle(); g.rd_en = 0;
    n_checks++;
    if ({g.rvalid, g.rdata, g.count} !== {1'b1, 8'h5A, 5'd1}) begin
      n_fail++; $display("FAIL fwft_next: rvalid=%b rdata=%h count=%0d want 1 5a 1", g.rvalid, g.rdata, g.count);
    end
  endtask

  task automatic test_simultaneous_edges();
    f.flush = 1; cycle(); f.flush = 0;
    n_checks++;
    if ({f.overflow, f.underflow, f.count} !== {2'b00, 5'd0}) begin
      n_fail++; $display("FAIL flush_clear: ovf=%b udf=%b count=%0d want 0 0 0", f.overflow, f.underflow, f.count);
    end
    f.wr_en = 1; f.rd_en = 1; f.wdata = 8'h99; cycle(); f.wr_en = 0; f.rd_en = 0;
    n_checks++;
    if ({f.count, f.underflow, f.overflow, f.rvalid} !== {5'd1, 3'b100}) begin
      n_fail++; $display("FAIL wr_rd_empty: count=%0d udf=%b ovf=%b rvalid=%b want 1 1 0 0", f.count, f.underflow, f.overflow, f.rvalid);
    end
    f.rd_en = 1; cycle(); f.rd_en = 0;
    n_checks++;
    if ({f.rvalid, f.rdata} !== {1'b1, 8'h99}) begin
      n_fail++; $display("FAIL wr_rd_empty_data: rvalid=%b rdata=%h want 1 99", f.rvalid, f.rdata);
    end
    for (int i = 0; i < 16; i++) begin
      f.wr_en = 1; f.wdata = 8'(8'h50 + i); cycle();
    end
    f.rd_en = 1; f.wdata = 8'hEE; cycle(); f.wr_en = 0; f.rd_en = 0;
    n_checks++;
    if ({f.count, f.overflow, f.rvalid, f.rdata} !== {5'd15, 2'b11, 8'h50}) begin
      n_fail++; $display("FAIL wr_rd_full: count=%0d ovf=%b rvalid=%b rdata=%h want 15 1 1 50", f.count, f.overflow, f.rvalid, f.rdata);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 8; i++) begin
      f.rd_en = 1; cycle();
    end
    f.rd_en = 0;
    n_checks++;
    if ({f.count, f.overflow, f.rdata} !== {5'd7, 1'b1, 8'h58}) begin
      n_fail++; $display("FAIL pre_flush: count=%0d ovf=%b rdata=%h want 7 1 58", f.count, f.overflow, f.rdata);
    end
    f.flush = 1; f.wr_en = 1; f.wdata = 8'h77; cycle(); f.flush = 0; f.wr_en = 0;
    n_checks++;
    if ({f.count, flags_f()} !== {5'd0, 7'b0101000}) begin
      n_fail++; $display("FAIL flush: count=%0d flags=%b want 0 0101000", f.count, flags_f());
    end
    cycle();
    n_checks++;
    if (f.count !== 5'd0) begin n_fail++; $display("FAIL flush_drop: count=%0d want 0", f.count); end
    f.wr_en = 1; f.wdata = 8'h31; cycle(); f.wr_en = 0;
    f.rd_en = 1; cycle(); f.rd_en = 0;
    n_checks++;
    if ({f.rvalid, f.rdata, f.count} !== {1'b1, 8'h31, 5'd0}) begin
      n_fail++; $display("FAIL post_flush: rvalid=%b rdata=%h count=%0d want 1 31 0", f.rvalid, f.rdata, f.count);
    end
    for (int i = 0; i < 3; i++) begin
      f.wr_en = 1; f.wdata = 8'(8'hC0 + i); cycle();
    end
    rst_n = 0; f.flush = 1; f.wr_en = 1; f.rd_en = 1; cycle();
    rst_n = 1; idle_inputs();
    n_checks++;
    if ({f.count, flags_f(), f.rdata} !== {5'd0, 7'b0101000, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset: count=%0d flags=%b rdata=%h want 0 0101000 00", f.count, flags_f(), f.rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_steady_state();
    test_fwft();
    test_simultaneous_edges();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
